// File: rtl/uart_ctrl_regfile.sv
// UART control register file: 8-byte bus-mapped register bank driving the UART
// configuration, Rx FIFO pop/clear strobes and a sticky-status interrupt.
module uart_ctrl_regfile #(
    parameter logic [15:0] DEFAULT_PERIOD    = 16'd20,
    parameter logic [3:0]  DEFAULT_UP_TIME   = 4'd10,
    parameter logic [3:0]  DEFAULT_DOWN_TIME = 4'd5,
    parameter logic [3:0]  DEFAULT_MODE      = 4'b0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  AddrBus_i,
    input  logic        n_ChipSelect_i,
    input  logic        n_rd_i,
    input  logic        n_we_i,
    input  logic [7:0]  DataBus_i,
    output logic [7:0]  DataBus_o,
    input  logic        p_RxParityErr_i,
    input  logic        p_RxFrameErr_i,
    input  logic [7:0]  RxData_i,
    input  logic        p_RxFIFO_Empty_i,
    output logic        n_RxFIFO_Rd_o,
    output logic        n_RxFIFO_Clr_o,
    output logic        p_RxFrame_Func_En_o,
    output logic [15:0] BaudRateGen_o,
    output logic [7:0]  BitCompensation_o,
    output logic [4:0]  AcqNumPerBit_o,
    output logic        p_ParityEnable_o,
    output logic        p_BigEnd_o,
    output logic        ParityMethod_o,
    output logic [3:0]  UartMode_o,
    output logic        p_Irq_o
);
    logic       accCond, accPrev, accStart, rdStart, wrStart;
    logic [7:0] baudShadow, irqEn, rdMux;
    logic [2:0] sticky, stSet, stClr;
    logic [7:0] irqStat;

    // Both strobes low is not a valid access; a start is the rising edge of a valid one.
    assign accCond  = !n_ChipSelect_i && (n_rd_i ^ n_we_i);
    assign accStart = accCond && !accPrev;
    assign rdStart  = accStart && !n_rd_i;
    assign wrStart  = accStart && !n_we_i;

    assign irqStat = {4'b0, ~p_RxFIFO_Empty_i, sticky};
    assign stSet   = {rdStart && AddrBus_i == 3'd7 && p_RxFIFO_Empty_i,
                      p_RxFrameErr_i, p_RxParityErr_i};
    assign stClr   = (wrStart && AddrBus_i == 3'd6) ? DataBus_i[2:0] : 3'b0;

    always_comb begin
        rdMux = 8'h00;
        case (AddrBus_i)
            3'd0: rdMux = {6'b0, p_RxFrame_Func_En_o, 1'b0};
            3'd1: rdMux = {p_BigEnd_o, p_ParityEnable_o, ParityMethod_o, 1'b0, UartMode_o};
            3'd2: rdMux = BaudRateGen_o[7:0];
            3'd3: rdMux = BaudRateGen_o[15:8];
            3'd4: rdMux = BitCompensation_o;
            3'd5: rdMux = irqEn;
            3'd6: rdMux = irqStat;
            3'd7: rdMux = p_RxFIFO_Empty_i ? 8'h00 : RxData_i;
            default: rdMux = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        // Track the strobe level through reset so a held access cannot restart on release.
        accPrev <= accCond;
        if (!rst) begin
            BaudRateGen_o       <= DEFAULT_PERIOD;
            BitCompensation_o   <= {DEFAULT_UP_TIME, DEFAULT_DOWN_TIME};
            AcqNumPerBit_o      <= {1'b0, DEFAULT_UP_TIME} + {1'b0, DEFAULT_DOWN_TIME};
            p_ParityEnable_o    <= 1'b1;
            p_BigEnd_o          <= 1'b0;
            ParityMethod_o      <= 1'b1;
            UartMode_o          <= DEFAULT_MODE;
            p_RxFrame_Func_En_o <= 1'b0;
            irqEn               <= 8'h00;
            sticky              <= 3'b000;
            baudShadow          <= 8'h00;
            DataBus_o           <= 8'h00;
            p_Irq_o             <= 1'b0;
            n_RxFIFO_Rd_o       <= 1'b1;
            n_RxFIFO_Clr_o      <= 1'b1;
        end else begin
            n_RxFIFO_Rd_o  <= 1'b1;
            n_RxFIFO_Clr_o <= 1'b1;
            sticky         <= (sticky & ~stClr) | stSet;
            p_Irq_o        <= |(irqStat[3:0] & irqEn[3:0]);
            if (wrStart) begin
                case (AddrBus_i)
                    3'd0: begin
                        n_RxFIFO_Clr_o      <= ~DataBus_i[0];
                        p_RxFrame_Func_En_o <= DataBus_i[1];
                    end
                    3'd1: begin
                        p_BigEnd_o       <= DataBus_i[7];
                        p_ParityEnable_o <= DataBus_i[6];
                        ParityMethod_o   <= DataBus_i[5];
                        if ($onehot(DataBus_i[3:0])) UartMode_o <= DataBus_i[3:0];
                    end
                    3'd2: baudShadow    <= DataBus_i;
                    3'd3: BaudRateGen_o <= {DataBus_i, baudShadow};
                    3'd4: if (DataBus_i != 8'h00) begin
                        BitCompensation_o <= DataBus_i;
                        AcqNumPerBit_o    <= {1'b0, DataBus_i[7:4]} + {1'b0, DataBus_i[3:0]};
                    end
                    3'd5: irqEn <= DataBus_i;
                    default: ;
                endcase
            end
            if (rdStart) begin
                DataBus_o <= rdMux;
                if (AddrBus_i == 3'd7 && !p_RxFIFO_Empty_i) n_RxFIFO_Rd_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_ctrl_regfile.sv
// Self-checking bench for uart_ctrl_regfile: register vector table plus hand-built
// sequences for strobes, interrupts, FIFO pops and reset behaviour.
module tb_uart_ctrl_regfile;
    logic        clk = 0, rst = 0;
    logic [2:0]  AddrBus_i = 0;
    logic        n_ChipSelect_i = 1, n_rd_i = 1, n_we_i = 1;
    logic [7:0]  DataBus_i = 0, DataBus_o;
    logic        p_RxParityErr_i = 0, p_RxFrameErr_i = 0;
    logic [7:0]  RxData_i = 8'hA5;
    logic        p_RxFIFO_Empty_i = 1;
    logic        n_RxFIFO_Rd_o, n_RxFIFO_Clr_o, p_RxFrame_Func_En_o;
    logic [15:0] BaudRateGen_o;
    logic [7:0]  BitCompensation_o;
    logic [4:0]  AcqNumPerBit_o;
    logic        p_ParityEnable_o, p_BigEnd_o, ParityMethod_o, p_Irq_o;
    logic [3:0]  UartMode_o;

    int total = 0, bad = 0, popCnt = 0, popSnap;
    logic [7:0] expQ[$];

    typedef struct { bit isWr; logic [2:0] addr; logic [7:0] data; } vec_t;
    vec_t tbl[18];

    uart_ctrl_regfile dut (
        .clk(clk), .rst(rst), .AddrBus_i(AddrBus_i), .n_ChipSelect_i(n_ChipSelect_i),
        .n_rd_i(n_rd_i), .n_we_i(n_we_i), .DataBus_i(DataBus_i), .DataBus_o(DataBus_o),
        .p_RxParityErr_i(p_RxParityErr_i), .p_RxFrameErr_i(p_RxFrameErr_i),
        .RxData_i(RxData_i), .p_RxFIFO_Empty_i(p_RxFIFO_Empty_i),
        .n_RxFIFO_Rd_o(n_RxFIFO_Rd_o), .n_RxFIFO_Clr_o(n_RxFIFO_Clr_o),
        .p_RxFrame_Func_En_o(p_RxFrame_Func_En_o), .BaudRateGen_o(BaudRateGen_o),
        .BitCompensation_o(BitCompensation_o), .AcqNumPerBit_o(AcqNumPerBit_o),
        .p_ParityEnable_o(p_ParityEnable_o), .p_BigEnd_o(p_BigEnd_o),
        .ParityMethod_o(ParityMethod_o), .UartMode_o(UartMode_o), .p_Irq_o(p_Irq_o)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (n_RxFIFO_Rd_o === 1'b0) popCnt++;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        AddrBus_i = a; DataBus_i = d; n_ChipSelect_i = 0; n_we_i = 0;
        @(negedge clk);
        n_ChipSelect_i = 1; n_we_i = 1;
    endtask

    task automatic rd(input string name, input logic [2:0] a, input logic [7:0] exp, input int hold);
        logic [7:0] e;
        expQ.push_back(exp);
        @(negedge clk);
        AddrBus_i = a; n_ChipSelect_i = 0; n_rd_i = 0;
        repeat (hold) @(negedge clk);
        e = expQ.pop_front();
        chk(name, DataBus_o, e);
        n_ChipSelect_i = 1; n_rd_i = 1;
    endtask

    initial begin
        tbl[0]  = '{1'b0, 3'd0, 8'h02};
        tbl[1]  = '{1'b0, 3'd1, 8'h24};
        tbl[2]  = '{1'b0, 3'd2, 8'h34};
        tbl[3]  = '{1'b0, 3'd3, 8'h12};
        tbl[4]  = '{1'b0, 3'd4, 8'hFF};
        tbl[5]  = '{1'b1, 3'd5, 8'h0F};
        tbl[6]  = '{1'b0, 3'd5, 8'h0F};
        tbl[7]  = '{1'b1, 3'd4, 8'h37};
        tbl[8]  = '{1'b0, 3'd4, 8'h37};
        tbl[9]  = '{1'b1, 3'd1, 8'h99};
        tbl[10] = '{1'b0, 3'd1, 8'h84};
        tbl[11] = '{1'b1, 3'd6, 8'hFF};
        tbl[12] = '{1'b0, 3'd6, 8'h00};
        tbl[13] = '{1'b1, 3'd7, 8'h55};
        tbl[14] = '{1'b0, 3'd3, 8'h12};
        tbl[15] = '{1'b1, 3'd2, 8'h77};
        tbl[16] = '{1'b0, 3'd2, 8'h34};
        tbl[17] = '{1'b0, 3'd5, 8'h0F};

        repeat (3) @(negedge clk);
        chk("rst_baud", BaudRateGen_o, 16'd20);
        chk("rst_comp", BitCompensation_o, 8'hA5);
        chk("rst_acq", AcqNumPerBit_o, 15);
        chk("rst_cfg", {p_ParityEnable_o, p_BigEnd_o, ParityMethod_o, UartMode_o}, 7'b1_0_1_0001);
        chk("rst_misc", {p_RxFrame_Func_En_o, p_Irq_o, n_RxFIFO_Rd_o, n_RxFIFO_Clr_o, DataBus_o}, 12'b0011_0000_0000);
        rst = 1;

        wr(3'd2, 8'h34); chk("baud_shadow_only", BaudRateGen_o, 16'd20);
        wr(3'd3, 8'h12); chk("baud_commit", BaudRateGen_o, 16'h1234);

        wr(3'd4, 8'hFF); chk("comp_ff_acq", AcqNumPerBit_o, 30);
        chk("comp_ff", BitCompensation_o, 8'hFF);
        wr(3'd4, 8'h00); chk("comp_zero_acq", AcqNumPerBit_o, 30);
        chk("comp_zero", BitCompensation_o, 8'hFF);

        wr(3'd1, 8'hE3);
        chk("mode_e3", {p_BigEnd_o, p_ParityEnable_o, ParityMethod_o, UartMode_o}, 7'b111_0001);
        wr(3'd1, 8'h04);
        chk("mode_04", {p_BigEnd_o, p_ParityEnable_o, ParityMethod_o, UartMode_o}, 7'b000_0100);
        wr(3'd1, 8'h24);
        chk("method_indep", {p_BigEnd_o, p_ParityEnable_o, ParityMethod_o, UartMode_o}, 7'b001_0100);

        wr(3'd0, 8'h03);
        chk("clr_pulse", n_RxFIFO_Clr_o, 0);
        chk("frame_en", p_RxFrame_Func_En_o, 1);
        @(negedge clk); chk("clr_one_cycle", n_RxFIFO_Clr_o, 1);
        wr(3'd0, 8'h02); chk("clr_none", n_RxFIFO_Clr_o, 1);

        for (int i = 0; i < 18; i++) begin
            if (tbl[i].isWr) wr(tbl[i].addr, tbl[i].data);
            else rd($sformatf("tbl%0d_a%0d", i, tbl[i].addr), tbl[i].addr, tbl[i].data, 1);
        end

        // Underrun on empty FIFO raises sticky bit 2, irq follows a cycle later.
        wr(3'd5, 8'h04);
        popSnap = popCnt;
        @(negedge clk);
        AddrBus_i = 3'd7; n_ChipSelect_i = 0; n_rd_i = 0;
        @(negedge clk);
        chk("empty_rd_data", DataBus_o, 8'h00);
        chk("empty_rd_irq_lag", p_Irq_o, 0);
        @(negedge clk);
        chk("empty_rd_irq", p_Irq_o, 1);
        chk("empty_no_pop", popCnt - popSnap, 0);
        n_ChipSelect_i = 1; n_rd_i = 1;
        rd("stat_underrun", 3'd6, 8'h04, 1);
        wr(3'd6, 8'h04);
        rd("stat_underrun_clr", 3'd6, 8'h00, 1);
        chk("irq_clr", p_Irq_o, 0);

        // Set beats write-1-to-clear in the same cycle.
        wr(3'd5, 8'h03);
        @(negedge clk); p_RxParityErr_i = 1;
        @(negedge clk); p_RxParityErr_i = 0;
        @(negedge clk);
        AddrBus_i = 3'd6; DataBus_i = 8'h01; n_ChipSelect_i = 0; n_we_i = 0; p_RxParityErr_i = 1;
        @(negedge clk);
        n_ChipSelect_i = 1; n_we_i = 1; p_RxParityErr_i = 0;
        rd("set_wins", 3'd6, 8'h01, 1);
        chk("par_irq", p_Irq_o, 1);
        wr(3'd6, 8'h01);
        rd("par_clr", 3'd6, 8'h00, 1);
        @(negedge clk); p_RxFrameErr_i = 1;
        @(negedge clk); p_RxFrameErr_i = 0;
        rd("frame_set", 3'd6, 8'h02, 1);
        wr(3'd6, 8'h02);
        rd("frame_clr", 3'd6, 8'h00, 1);

        // Held read strobe pops exactly once.
        p_RxFIFO_Empty_i = 0; RxData_i = 8'hA5;
        popSnap = popCnt;
        rd("rx_data", 3'd7, 8'hA5, 5);
        repeat (2) @(negedge clk);
        chk("one_pop", popCnt - popSnap, 1);
        chk("data_hold", DataBus_o, 8'hA5);
        rd("stat_live", 3'd6, 8'h08, 1);

        // Both strobes low is ignored.
        @(negedge clk);
        AddrBus_i = 3'd5; DataBus_i = 8'hAA; n_ChipSelect_i = 0; n_rd_i = 0; n_we_i = 0;
        repeat (2) @(negedge clk);
        n_ChipSelect_i = 1; n_rd_i = 1; n_we_i = 1;
        rd("both_low_ignored", 3'd5, 8'h03, 1);

        // Strobe held across reset must not restart on release.
        @(negedge clk);
        AddrBus_i = 3'd5; DataBus_i = 8'h33; n_ChipSelect_i = 0; n_we_i = 0;
        @(negedge clk); rst = 0;
        repeat (2) @(negedge clk); rst = 1;
        repeat (2) @(negedge clk);
        n_ChipSelect_i = 1; n_we_i = 1;
        chk("rst_mid_baud", BaudRateGen_o, 16'd20);
        rd("rst_mid_no_restart", 3'd5, 8'h00, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
